// File: rtl/sfifo_level_if.sv
// Stream handshake bundle: data word plus valid/ready.
// master drives data/valid and samples ready; slave does the reverse.
// One instance per stream direction (producer side, consumer side).
interface sfifo_level_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sfifo_level.sv
// Synchronous stream FIFO with occupancy level, almost-full/empty flags and flush.
// Latency: a word accepted at an edge into an empty FIFO is on sender right after that edge.
// Backpressure: receiver.ready drops when full (ignores same-cycle pop); sender holds while !ready.
//
// Ports: clock/reset (sync, active-high), flush (sync discard), receiver (slave stream in),
//        sender (master stream out), level (words held 0..DEPTH), almost_full, almost_empty.
//        Every output comes straight from a flop.
module sfifo_level #(
  parameter  int WIDTH        = 32,
  parameter  int DEPTH        = 256,
  parameter  int AFULL_LEVEL  = DEPTH - 4,
  parameter  int AEMPTY_LEVEL = 4,
  localparam int LW           = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  sfifo_level_if.slave  receiver,
  sfifo_level_if.master sender,
  output logic [LW-1:0] level,
  output logic          almost_full,
  output logic          almost_empty
);

  // Storage is a RAM of DEPTH-1 words plus the head register, DEPTH words in total.
  localparam int RAMD = DEPTH - 1;
  localparam int PW   = (RAMD > 1) ? $clog2(RAMD) : 1;

  logic [WIDTH-1:0] mem [RAMD];
  logic [WIDTH-1:0] head_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          valid_q,  valid_d;
  logic          ready_q,  ready_d;
  logic          afull_q,  afull_d;
  logic          aempty_q, aempty_d;

  logic push, pop, head_load, ram_has_data, clear;
  logic ram_wr, ram_rd, bypass;

  // Explicit wrap so any RAM depth works, not just powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RAMD - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    push  = receiver.valid && ready_q;
    pop   = valid_q && sender.ready;
    clear = reset || flush;

    // The head is valid whenever level > 0, so the RAM holds level-1 words.
    head_load    = !valid_q || pop;
    ram_has_data = level_q > LW'(1);

    // Head refills from the RAM if it has anything; otherwise an incoming word
    // goes straight into the head so an empty FIFO has single-edge latency.
    ram_rd = head_load && ram_has_data && !clear;
    bypass = head_load && !ram_has_data && push && !clear;
    ram_wr = push && !bypass && !clear;

    wr_ptr_d = ram_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = ram_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    valid_d  = head_load ? (ram_has_data || push) : valid_q;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      valid_d  = 1'b0;
      level_d  = '0;
    end

    // Status flops are computed from the next level so they always agree with it.
    ready_d  = !reset && (level_d < LW'(DEPTH));
    afull_d  = level_d >= LW'(AFULL_LEVEL);
    aempty_d = level_d <= LW'(AEMPTY_LEVEL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Data path without reset: RAM write port and registered read into the head.
  // Read and write never target the same entry in one cycle (RAM is neither
  // empty-and-read nor full-and-written).
  always_ff @(posedge clock) begin
    if (ram_wr) begin
      mem[wr_ptr_q] <= receiver.data;
    end
    if (ram_rd) begin
      head_q <= mem[rd_ptr_q];
    end else if (bypass) begin
      head_q <= receiver.data;
    end
  end

  assign receiver.ready = ready_q;
  assign sender.valid   = valid_q;
  assign sender.data    = head_q;
  assign level          = level_q;
  assign almost_full    = afull_q;
  assign almost_empty   = aempty_q;

endmodule

// File: tb/tb_sfifo_level.sv
module tb_sfifo_level;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       flush8;
  logic       flush5;
  logic [3:0] level8;
  logic [2:0] level5;
  logic       af8, ae8, af5, ae5;

  sfifo_level_if #(.WIDTH(32)) rx8 ();
  sfifo_level_if #(.WIDTH(32)) tx8 ();
  sfifo_level_if #(.WIDTH(32)) rx5 ();
  sfifo_level_if #(.WIDTH(32)) tx5 ();

  sfifo_level #(.WIDTH(32), .DEPTH(8), .AFULL_LEVEL(4), .AEMPTY_LEVEL(4)) u8 (
    .clock(clock), .reset(reset), .flush(flush8),
    .receiver(rx8), .sender(tx8),
    .level(level8), .almost_full(af8), .almost_empty(ae8)
  );

  sfifo_level #(.WIDTH(32), .DEPTH(5), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)) u5 (
    .clock(clock), .reset(reset), .flush(flush5),
    .receiver(rx5), .sender(tx5),
    .level(level5), .almost_full(af5), .almost_empty(ae5)
  );

  int tests = 0;
  int fails = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush8 = 1'b0; flush5 = 1'b0;
    rx8.valid = 1'b0; rx8.data = '0; tx8.ready = 1'b0;
    rx5.valid = 1'b0; rx5.data = '0; tx5.ready = 1'b0;
    step(); step();
    tests++; if (rx8.ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_reset: got %b want 0", rx8.ready); end
    tests++; if (level8 !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", level8); end
    tests++; if (tx8.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", tx8.valid); end
    tests++; if (ae8 !== 1'b1) begin fails++; $display("FAIL reset_aempty: got %b want 1", ae8); end
    tests++; if (af8 !== 1'b0) begin fails++; $display("FAIL reset_afull: got %b want 0", af8); end
    reset = 1'b0;
    step();
    tests++; if (rx8.ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", rx8.ready); end
    tests++; if (rx5.ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after_d5: got %b want 1", rx5.ready); end
    tests++; if (level8 !== 4'd0) begin fails++; $display("FAIL reset_level_after: got %0d want 0", level8); end
  endtask

  task automatic test_single();
    tx8.ready = 1'b1;
    rx8.valid = 1'b1; rx8.data = 32'h11;
    step();
    rx8.valid = 1'b0;
    tests++; if (tx8.valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", tx8.valid); end
    tests++; if (tx8.data !== 32'h11) begin fails++; $display("FAIL single_data: got %h want 11", tx8.data); end
    tests++; if (level8 !== 4'd1) begin fails++; $display("FAIL single_level: got %0d want 1", level8); end
    step();
    tests++; if (tx8.valid !== 1'b0) begin fails++; $display("FAIL single_popped_valid: got %b want 0", tx8.valid); end
    tests++; if (level8 !== 4'd0) begin fails++; $display("FAIL single_popped_level: got %0d want 0", level8); end
    tx8.ready = 1'b0;
  endtask

  task automatic test_fill();
    int exp = 0;
    tx8.ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      rx8.valid = 1'b1; rx8.data = i;
      step();
      if (exp < 8) exp++;
      tests++; if (level8 !== 4'(exp)) begin fails++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level8, exp); end
      tests++; if (rx8.ready !== (exp < 8)) begin fails++; $display("FAIL fill_ready[%0d]: got %b want %b", i, rx8.ready, exp < 8); end
      tests++; if (af8 !== (exp >= 4)) begin fails++; $display("FAIL fill_afull[%0d]: got %b want %b", i, af8, exp >= 4); end
      tests++; if (ae8 !== (exp <= 4)) begin fails++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, ae8, exp <= 4); end
    end
    rx8.valid = 1'b0;
    tx8.ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tests++; if (tx8.valid !== 1'b1 || tx8.data !== 32'(k)) begin
        fails++; $display("FAIL drain[%0d]: got valid=%b data=%0d want valid=1 data=%0d", k, tx8.valid, tx8.data, k);
      end
      step();
    end
    tests++; if (level8 !== 4'd0 || tx8.valid !== 1'b0) begin
      fails++; $display("FAIL drain_empty: got level=%0d valid=%b want 0/0", level8, tx8.valid);
    end
    tx8.ready = 1'b0;
  endtask

  task automatic test_full_balance();
    logic [31:0] q[$];
    int exp = 0;
    logic vld, rdy, m_push, m_pop;
    logic [31:0] dat;
    tx8.ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx8.valid = 1'b1; rx8.data = 32'h100 + i;
      q.push_back(32'h100 + i);
      step();
      exp++;
    end
    tests++; if (level8 !== 4'd8) begin fails++; $display("FAIL bal_full_level: got %0d want 8", level8); end
    for (int c = 0; c < 1001; c++) begin
      if (c == 0) begin vld = 1'b1; rdy = 1'b1; end
      else begin vld = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 3) != 0); end
      dat = 32'h1000 + c;
      rx8.valid = vld; rx8.data = dat; tx8.ready = rdy;
      m_push = vld && (exp < 8);
      m_pop  = rdy && (exp > 0);
      tests++; if (tx8.valid !== (exp > 0)) begin fails++; $display("FAIL bal_valid[%0d]: got %b want %b", c, tx8.valid, exp > 0); end
      if (m_pop && q.size() > 0) begin
        tests++; if (tx8.data !== q[0]) begin fails++; $display("FAIL bal_data[%0d]: got %h want %h", c, tx8.data, q[0]); end
        void'(q.pop_front());
      end
      if (m_push) q.push_back(dat);
      step();
      exp = exp + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      if (c == 0) begin
        tests++; if (level8 !== 4'd7) begin fails++; $display("FAIL bal_first_pop_level: got %0d want 7", level8); end
      end
      tests++; if (level8 !== 4'(exp)) begin fails++; $display("FAIL bal_level[%0d]: got %0d want %0d", c, level8, exp); end
      tests++; if (rx8.ready !== (exp < 8)) begin fails++; $display("FAIL bal_ready[%0d]: got %b want %b", c, rx8.ready, exp < 8); end
    end
    rx8.valid = 1'b0; tx8.ready = 1'b1;
    for (int g = 0; g < 20 && q.size() > 0; g++) begin
      tests++; if (tx8.valid !== 1'b1 || tx8.data !== q[0]) begin
        fails++; $display("FAIL bal_drain: got valid=%b data=%h want 1/%h", tx8.valid, tx8.data, q[0]);
      end
      void'(q.pop_front());
      step();
    end
    tests++; if (level8 !== 4'd0 || tx8.valid !== 1'b0) begin
      fails++; $display("FAIL bal_end_empty: got level=%0d valid=%b want 0/0", level8, tx8.valid);
    end
    tx8.ready = 1'b0;
  endtask

  task automatic test_wrap();
    int sent = 0, got = 0, exp = 0, cyc = 0;
    logic vld, rdy, m_push, m_pop;
    while (got < 20 && cyc < 600) begin
      vld = (sent < 20) && ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      rx5.valid = vld; rx5.data = 32'(sent * 3 + 7); tx5.ready = rdy;
      m_push = vld && (exp < 5);
      m_pop  = rdy && (exp > 0);
      tests++; if (tx5.valid !== (exp > 0)) begin fails++; $display("FAIL wrap_valid[%0d]: got %b want %b", cyc, tx5.valid, exp > 0); end
      if (m_pop) begin
        tests++; if (tx5.data !== 32'(got * 3 + 7)) begin fails++; $display("FAIL wrap_data[%0d]: got %0d want %0d", got, tx5.data, got * 3 + 7); end
        got++;
      end
      if (m_push) sent++;
      step();
      exp = exp + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      tests++; if (level5 !== 3'(exp)) begin fails++; $display("FAIL wrap_level[%0d]: got %0d want %0d", cyc, level5, exp); end
      tests++; if (rx5.ready !== (exp < 5)) begin fails++; $display("FAIL wrap_ready[%0d]: got %b want %b", cyc, rx5.ready, exp < 5); end
      tests++; if (af5 !== (exp >= 4) || ae5 !== (exp <= 1)) begin
        fails++; $display("FAIL wrap_flags[%0d]: got af=%b ae=%b want %b/%b", cyc, af5, ae5, exp >= 4, exp <= 1);
      end
      cyc++;
    end
    rx5.valid = 1'b0; tx5.ready = 1'b0;
    tests++; if (got != 20) begin fails++; $display("FAIL wrap_timeout: got %0d words want 20", got); end
  endtask

  task automatic test_flush();
    tx8.ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx8.valid = 1'b1; rx8.data = 32'h60 + i;
      step();
    end
    rx8.valid = 1'b0;
    tests++; if (level8 !== 4'd6) begin fails++; $display("FAIL flush_pre_level: got %0d want 6", level8); end
    flush8 = 1'b1; rx8.valid = 1'b1; rx8.data = 32'hAA; tx8.ready = 1'b1;
    tests++; if (rx8.ready !== 1'b1) begin fails++; $display("FAIL flush_ready_during: got %b want 1", rx8.ready); end
    step();
    flush8 = 1'b0; rx8.valid = 1'b0; tx8.ready = 1'b0;
    tests++; if (level8 !== 4'd0) begin fails++; $display("FAIL flush_level: got %0d want 0", level8); end
    tests++; if (tx8.valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", tx8.valid); end
    tests++; if (ae8 !== 1'b1 || af8 !== 1'b0) begin fails++; $display("FAIL flush_flags: got ae=%b af=%b want 1/0", ae8, af8); end
    tests++; if (rx8.ready !== 1'b1) begin fails++; $display("FAIL flush_ready_after: got %b want 1", rx8.ready); end
    rx8.valid = 1'b1; rx8.data = 32'hBB;
    step();
    rx8.valid = 1'b0;
    tests++; if (tx8.valid !== 1'b1 || tx8.data !== 32'hBB) begin
      fails++; $display("FAIL flush_first_out: got valid=%b data=%h want 1/bb", tx8.valid, tx8.data);
    end
    tests++; if (level8 !== 4'd1) begin fails++; $display("FAIL flush_bb_level: got %0d want 1", level8); end
    tx8.ready = 1'b1;
    step();
    step();
    tests++; if (tx8.valid !== 1'b0 || level8 !== 4'd0) begin
      fails++; $display("FAIL flush_no_stale: got valid=%b data=%h level=%0d want 0/-/0", tx8.valid, tx8.data, level8);
    end
    tx8.ready = 1'b0;
  endtask

  task automatic test_reset_midburst();
    tx8.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx8.valid = 1'b1; rx8.data = 32'h50 + i;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0; rx8.valid = 1'b0;
    step();
    tests++; if (tx8.valid !== 1'b0 || level8 !== 4'd0) begin
      fails++; $display("FAIL midreset_empty: got valid=%b level=%0d want 0/0", tx8.valid, level8);
    end
    tests++; if (rx8.ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", rx8.ready); end
    rx8.valid = 1'b1; rx8.data = 32'h77;
    step();
    rx8.valid = 1'b0;
    tests++; if (tx8.valid !== 1'b1 || tx8.data !== 32'h77) begin
      fails++; $display("FAIL midreset_first_out: got valid=%b data=%h want 1/77", tx8.valid, tx8.data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_balance();
    test_wrap();
    test_flush();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
